uart_char_sender: RTL and testbench

- Push-button-driven UART character transmitter for board bring-up.
- One tact switch (i_cnt) steps a character register through 'A'..'Z'.
- A second tact switch (i_sed) sends the current character once as an 8N1 frame on o_txd.
- Sits between the board buttons and the UART TX pin. Baud timing and button filtering are parameterised so simulation can use tiny values.

---
 rtl/uart_char_sender_pkg.sv | 19 +
 rtl/uart_char_sender_tx.sv | 112 +++++++++++
 rtl/uart_char_sender.sv | 80 ++++++++
 tb/tb_uart_char_sender.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_char_sender_pkg.sv
// Shared types and constants for the push-button UART character sender.
// The character register walks the uppercase alphabet and wraps.
package uart_char_sender_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic [7:0] CHAR_FIRST = 8'h41;  // 'A'
  localparam logic [7:0] CHAR_LAST  = 8'h5A;  // 'Z'

  function automatic logic [7:0] next_char(input logic [7:0] c);
    return (c == CHAR_LAST) ? CHAR_FIRST : c + 8'd1;
  endfunction

endpackage

// File: rtl/uart_char_sender_tx.sv
// 8N1 serial transmitter: start bit, eight data bits LSB first, stop bit,
// each held for D clock cycles. Start requests while busy are dropped.
module uart_tx
  import uart_char_sender_pkg::*;
#(
  parameter int D = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       txd
);

  localparam int TW = (D > 1) ? $clog2(D) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(D - 1);

  tx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          bit_done;

  assign bit_done = (timer_q == TIMER_LAST);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  // NOTE: every output of this block is defaulted first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    txd_d   = txd_q;

    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (start) begin
          shift_d = data;
          timer_d = '0;
          txd_d   = 1'b0;
          state_d = START;
        end
      end

      START: begin
        if (bit_done) begin
          timer_d = '0;
          idx_d   = '0;
          txd_d   = shift_q[0];
          state_d = DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      DATA: begin
        if (bit_done) begin
          timer_d = '0;
          if (idx_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      STOP: begin
        if (bit_done) begin
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign txd  = txd_q;

endmodule

// File: rtl/uart_char_sender.sv
// Button-driven UART sender: the count button steps 'A'..'Z', the send
// button transmits the current character once as an 8N1 frame.
module uart_char_sender
  import uart_char_sender_pkg::*;
#(
  parameter int D = 5,
  parameter int L = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sed,
  input  logic i_cnt,
  output logic o_txd
);

  localparam int BTN_SED = 0;
  localparam int BTN_CNT = 1;

  logic [1:0]        btn_raw;
  logic [1:0]        sync1, sync2;
  logic [1:0][L-1:0] samples;
  logic [1:0]        level, level_q;
  logic [1:0]        pulse;

  logic [7:0]        char_q;
  logic              tx_busy;
  logic              tx_start;

  assign btn_raw = {i_cnt, i_sed};

  // Two-flop synchronizer, L-sample agreement filter with hysteresis, and
  // rising-edge detect on the filtered level, for both buttons at once.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync1   <= '0;
      sync2   <= '0;
      samples <= '0;
      level   <= '0;
      level_q <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_q <= level;
      for (int b = 0; b < 2; b++) begin
        samples[b] <= L'({samples[b], sync2[b]});
        if (&samples[b]) begin
          level[b] <= 1'b1;
        end else if (~|samples[b]) begin
          level[b] <= 1'b0;
        end
      end
    end
  end

  assign pulse = level & ~level_q;

  // The transmitter latches char_q on the same edge that a simultaneous
  // count pulse updates it, so it always captures the pre-increment value.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      char_q <= CHAR_FIRST;
    end else if (pulse[BTN_CNT]) begin
      char_q <= next_char(char_q);
    end
  end

  assign tx_start = pulse[BTN_SED] & ~tx_busy;

  uart_tx #(
    .D(D)
  ) u_tx (
    .clk   (i_clk),
    .rst_n (i_rst),
    .start (tx_start),
    .data  (char_q),
    .busy  (tx_busy),
    .txd   (o_txd)
  );

endmodule

// File: tb/tb_uart_char_sender.sv
// Scoreboard bench: senders queue the expected byte, an independent monitor
// decodes every frame on o_txd cycle by cycle and compares.
module tb_uart_char_sender;

  localparam int D = 5;
  localparam int L = 3;
  localparam int HOLD = L + 4;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  logic i_sed = 1'b0;
  logic i_cnt = 1'b0;
  logic o_txd;

  int errors  = 0;
  int checks  = 0;
  int aborted = 0;
  bit mon_busy = 1'b0;
  logic [7:0] sb[$];

  uart_char_sender #(.D(D), .L(L)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_sed (i_sed),
    .i_cnt (i_cnt),
    .o_txd (o_txd)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic press(input bit cnt, input bit sed, input int hi);
    @(negedge i_clk);
    i_cnt = cnt;
    i_sed = sed;
    tick(hi);
    i_cnt = 1'b0;
    i_sed = 1'b0;
    tick(HOLD);
  endtask

  task automatic count(input int n);
    for (int k = 0; k < n; k++) press(1'b1, 1'b0, HOLD);
  endtask

  task automatic send(input logic [7:0] exp);
    sb.push_back(exp);
    press(1'b0, 1'b1, HOLD);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || mon_busy) && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    check("drain", n < 3000, 1);
    tick(3 * D);
  endtask

  // Monitor: a low o_txd out of reset marks the first cycle of a start bit.
  initial begin
    logic [9:0] frame;
    logic [7:0] exp, got;
    int bad;
    bit have, abort;
    forever begin
      @(negedge i_clk);
      if (i_rst === 1'b1 && o_txd === 1'b0) begin
        mon_busy = 1'b1;
        have  = (sb.size() != 0);
        check("frame_expected", have, 1);
        exp   = have ? sb.pop_front() : 8'h00;
        frame = {1'b1, exp, 1'b0};
        got   = '0;
        bad   = 0;
        abort = 1'b0;
        for (int b = 0; b < 10 && !abort; b++) begin
          for (int c = 0; c < D && !abort; c++) begin
            if (b != 0 || c != 0) @(negedge i_clk);
            if (i_rst !== 1'b1) begin
              abort = 1'b1;
            end else begin
              if (o_txd !== frame[b]) bad++;
              if (c == D / 2 && b >= 1 && b <= 8) got[b-1] = o_txd;
            end
          end
        end
        if (abort) begin
          aborted++;
        end else if (have) begin
          check("frame_data", got, exp);
          check("frame_timing", bad, 0);
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    int n;

    // Reset and quiet idle
    tick(1);
    #1 check("reset_txd", o_txd, 1);
    tick(3);
    i_rst = 1'b1;
    tick(1);
    check("post_reset_txd", o_txd, 1);
    tick(100);
    check("idle_txd", o_txd, 1);

    // Single send of the reset character
    send(8'h41);
    drain();
    check("after_frame_txd", o_txd, 1);

    // Ten counts from 'A' gives 'K'
    count(10);
    send(8'h4B);
    drain();

    // Up to 'Z', then wrap to 'A'
    count(15);
    send(8'h5A);
    drain();
    count(1);
    send(8'h41);
    drain();

    // Full alphabet cycle returns to 'A'
    count(26);
    send(8'h41);
    drain();

    // Short glitch is filtered out
    press(1'b1, 1'b0, L - 1);
    send(8'h41);
    drain();

    // Long hold counts once
    press(1'b1, 1'b0, 100);
    send(8'h42);
    drain();

    // Second send mid-frame is ignored
    send(8'h42);
    press(1'b0, 1'b1, HOLD);
    drain();

    // Count mid-frame does not disturb the frame in flight
    send(8'h42);
    count(1);
    drain();
    send(8'h43);
    drain();

    // Count and send together: old value goes out
    sb.push_back(8'h43);
    press(1'b1, 1'b1, HOLD);
    drain();
    send(8'h44);
    drain();

    // Reset during data bit 3 abandons the frame
    sb.push_back(8'h44);
    @(negedge i_clk);
    i_sed = 1'b1;
    n = 0;
    while (o_txd !== 1'b0 && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    check("mid_rst_frame_start", n < 200, 1);
    i_sed = 1'b0;
    tick(4 * D + 2);
    #2 i_rst = 1'b0;
    #1 check("mid_rst_txd", o_txd, 1);
    tick(3);
    i_rst = 1'b1;
    tick(HOLD);
    check("mid_rst_aborted", aborted, 1);
    send(8'h41);
    drain();

    check("scoreboard_empty", sb.size(), 0);
    check("final_txd", o_txd, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
